receiver_deframer: RTL and testbench
====================================

Name: receiver_deframer

Overview:
- Receive-side link stage that sits directly upstream of the receiver DAC output.
- Takes the recovered serial bit stream from the link and hunts for the sync word.
- Collects a fixed-length payload of 8-bit samples, then checks a CRC-8 over that payload.
- Plays verified samples out to the DAC bus; drives the link-lock indication that the wrapper exports as receiver_sync_out.

Parameters:
- SYNC_W, 16, sync word width in bits.
- SYNC_WORD, 16'hA5C3, frame delimiter, MSB first on the wire.
- PAYLOAD_LEN, 8, payload samples per frame (range 1..64).
- MISS_LIMIT, 3, consecutive bad frames before lock is dropped (range 1..15).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- bit_valid  in  1  qualifies bit_in; at most one bit per cycle.
- bit_in  in  1  serial link bit, MSB first.
- da_out  out  8  sample to DAC; holds its last value between updates.
- da_valid  out  1  one-cycle strobe, high when da_out updates.
- sync_out  out  1  link locked.
- frame_ok  out  1  one-cycle pulse when a frame passes CRC.
- frame_err  out  1  one-cycle pulse when a frame fails CRC.
- err_count  out  16  bad-frame counter; see Optional Feature.

Behaviour:
- Reset (async assert, sync release): state HUNT; shift register, CRC, counters and buffers all 0.
- Reset values of outputs: da_out=0, da_valid=0, sync_out=0, frame_ok=0, frame_err=0, err_count=0.
- Reset mid-frame or mid-playout: abandons everything, no pulses emitted.
- Only cycles with bit_valid=1 advance the rx FSM; bit_valid=0 holds all rx state.
- HUNT:
  - Shift bit_in into an SYNC_W-bit register.
  - When the register including the current bit equals SYNC_WORD, go to PAYLOAD; clear the bit counter and CRC.
  - Overlapping matches are allowed.
- PAYLOAD:
  - Assemble bytes MSB first into rx buffer [0..PAYLOAD_LEN-1].
  - Each bit feeds the serial CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR).
  - After 8*PAYLOAD_LEN bits, go to CRC.
  - A sync-word pattern inside the payload is ignored.
- CRC: collect 8 bits MSB first. On the 8th bit, compare against the computed CRC; the result is registered and the pulse appears the next cycle.
  - Match: frame_ok=1 for 1 cycle; copy the rx buffer to the play buffer; start playout; miss counter=0; sync_out=1.
  - Mismatch: frame_err=1 for 1 cycle; miss counter +1, saturating. When it reaches MISS_LIMIT, sync_out=0.
  - Either way, return to HUNT with the shift register cleared.
- Playout (independent of the rx FSM):
  - Emits play[0..PAYLOAD_LEN-1] on consecutive cycles with da_valid=1.
  - The first byte appears the cycle after frame_ok.
- Latency: last CRC bit -> frame_ok is 1 cycle; -> first da_valid is 2 cycles.
- Overlap: a new frame can be received during playout. A new verified frame cannot arrive before playout ends (minimum frame length exceeds PAYLOAD_LEN cycles), so no collision handling is needed.
- Once a frame passes CRC, sync_out stays 1 through fewer than MISS_LIMIT consecutive CRC failures.

Optional Feature:
- Macro: DEFRAMER_ERR_CNT_EN.
- Defined: err_count increments on each frame_err pulse, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: err_count is tied to 0 and the counter logic is absent.

Decomposition:
- Package urllc_link_pkg holds:
  - SYNC_WORD default.
  - CRC8_POLY = 8'h07.
  - rx state enum {HUNT, PAYLOAD, CRC}.
  - Byte-width constant.
- Sub-module crc8_serial: inputs clear, enable and bit; output 8-bit crc. Shared with the future sender-side framer.

Test Plan:
- Single frame, 5 idle bits then SYNC_WORD, payload 0x01..0x08, correct CRC (bench model) -> frame_ok one pulse; da_valid for 8 consecutive cycles with da_out 0x01..0x08; sync_out=1; da_out holds 0x08 afterwards.
- Same frame with the CRC LSB flipped -> frame_err one pulse; no da_valid; sync_out stays 0.
- Lock, then 2 bad frames, then 1 good frame, then 3 bad frames -> sync_out stays 1 through the first two failures; falls on the 3rd consecutive frame_err.
- Payload containing bytes 0xA5,0xC3, with bit_valid toggled randomly at 50% -> frame decoded intact; no false resync; playout identical to the first test's pattern format.
- Reset asserted after 40 payload bits, then a full good frame -> no pulses from the aborted frame; the next frame is decoded normally; outputs read 0 during reset.
- With DEFRAMER_ERR_CNT_EN defined, 5 bad frames -> err_count=5; without the macro, err_count stays 0.

Source files
------------

// File: rtl/urllc_link_pkg.sv
// Shared link-layer constants and types for the receive deframer and the sender-side framer.
package urllc_link_pkg;
  localparam int          BYTE_W        = 8;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;
  localparam logic [7:0]  CRC8_POLY     = 8'h07;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CRC} rx_state_e;
endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB first, init 0, no reflection, no final XOR.
module crc8_serial
  import urllc_link_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic fb;
  assign fb = crc[7] ^ bit_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       crc <= '0;
    else if (clear)  crc <= '0;
    else if (enable) crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  end

endmodule

// File: rtl/receiver_deframer.sv
// Serial link deframer: sync hunt, payload capture, CRC-8 check, DAC playout.
// Optional bad-frame counter enabled by defining DEFRAMER_ERR_CNT_EN.
module receiver_deframer
  import urllc_link_pkg::*;
#(
  parameter int                SYNC_W      = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD   = SYNC_W'(SYNC_WORD_DEF),
  parameter int                PAYLOAD_LEN = 8,
  parameter int                MISS_LIMIT  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic [7:0]  da_out,
  output logic        da_valid,
  output logic        sync_out,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] err_count
);

  localparam int IDX_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);

  rx_state_e         state;
  logic [SYNC_W-2:0] shreg;
  logic [SYNC_W-1:0] shreg_nxt;
  logic [2:0]        bit_pos;
  logic [IDX_W-1:0]  byte_idx;
  logic [IDX_W-1:0]  play_idx;
  logic              play_active;
  logic [6:0]        crc_rx;
  logic [7:0]        crc_word;
  logic [7:0]        crc_calc;
  logic [3:0]        miss_cnt;
  logic              crc_clr;
  logic              crc_en;

  logic [BYTE_W-1:0] rx_buf   [PAYLOAD_LEN];
  logic [BYTE_W-1:0] play_buf [PAYLOAD_LEN];

  // Match includes the bit arriving this cycle, so overlapping syncs are caught.
  assign shreg_nxt = {shreg, bit_in};
  assign crc_word  = {crc_rx, bit_in};
  assign crc_clr   = bit_valid && (state == HUNT) && (shreg_nxt == SYNC_WORD);
  assign crc_en    = bit_valid && (state == PAYLOAD);

  crc8_serial u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clr),
    .enable (crc_en),
    .bit_in (bit_in),
    .crc    (crc_calc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      shreg     <= '0;
      bit_pos   <= '0;
      byte_idx  <= '0;
      crc_rx    <= '0;
      miss_cnt  <= '0;
      sync_out  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        rx_buf[i]   <= '0;
        play_buf[i] <= '0;
      end
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (bit_valid) begin
        case (state)
          HUNT: begin
            shreg <= shreg_nxt[SYNC_W-2:0];
            if (shreg_nxt == SYNC_WORD) begin
              state    <= PAYLOAD;
              bit_pos  <= '0;
              byte_idx <= '0;
            end
          end
          PAYLOAD: begin
            rx_buf[byte_idx] <= {rx_buf[byte_idx][6:0], bit_in};
            bit_pos          <= bit_pos + 3'd1;
            if (bit_pos == 3'd7) begin
              if (byte_idx == LAST_IDX) begin
                state    <= CRC;
                byte_idx <= '0;
              end else begin
                byte_idx <= byte_idx + 1'b1;
              end
            end
          end
          CRC: begin
            crc_rx  <= crc_word[6:0];
            bit_pos <= bit_pos + 3'd1;
            if (bit_pos == 3'd7) begin
              state <= HUNT;
              shreg <= '0;
              if (crc_word == crc_calc) begin
                frame_ok <= 1'b1;
                miss_cnt <= '0;
                sync_out <= 1'b1;
                for (int i = 0; i < PAYLOAD_LEN; i++) play_buf[i] <= rx_buf[i];
              end else begin
                frame_err <= 1'b1;
                if (miss_cnt < 4'(MISS_LIMIT)) miss_cnt <= miss_cnt + 4'd1;
                // This failure is the MISS_LIMIT-th in a row.
                if (miss_cnt >= 4'(MISS_LIMIT - 1)) sync_out <= 1'b0;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // Playout kicks off on frame_ok; play_buf was loaded on the same edge that raised it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      da_out      <= '0;
      da_valid    <= 1'b0;
      play_active <= 1'b0;
      play_idx    <= '0;
    end else if (frame_ok || play_active) begin
      da_out   <= play_buf[play_idx];
      da_valid <= 1'b1;
      if (play_idx == LAST_IDX) begin
        play_active <= 1'b0;
        play_idx    <= '0;
      end else begin
        play_active <= 1'b1;
        play_idx    <= play_idx + 1'b1;
      end
    end else begin
      da_valid <= 1'b0;
    end
  end

`ifdef DEFRAMER_ERR_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  err_count <= '0;
    else if (frame_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_receiver_deframer.sv
// Directed bench for receiver_deframer: framing, CRC pass/fail, lock hysteresis, resets.
module tb_receiver_deframer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic [7:0]  da_out;
  logic        da_valid;
  logic        sync_out;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;

  int         ok_q[$];
  int         err_q[$];
  int         dv_q[$];
  logic [7:0] dat_q[$];

  localparam logic [63:0] P1 = 64'h0102030405060708;
  localparam logic [63:0] P2 = 64'hA5C3030405060708;

  receiver_deframer dut (
    .clock     (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .da_out    (da_out),
    .da_valid  (da_valid),
    .sync_out  (sync_out),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_ok)  ok_q.push_back(cyc);
      if (frame_err) err_q.push_back(cyc);
      if (da_valid) begin
        dv_q.push_back(cyc);
        dat_q.push_back(da_out);
      end
    end
  end

  // Bytewise CRC-8 (poly 0x07, init 0) over the 8 payload bytes, first byte in the top bits.
  function automatic logic [7:0] crc8_model(input logic [63:0] pl);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      c = c ^ pl[63-8*i -: 8];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  task automatic clear_mon();
    ok_q.delete(); err_q.delete(); dv_q.delete(); dat_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_valid = 1'b0;
      bit_in    = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input bit rnd);
    for (int i = n - 1; i >= 0; i--) begin
      if (rnd) begin
        int s = 0;
        while (s < 3 && $urandom_range(0, 1) == 1) begin
          @(negedge clk);
          bit_valid = 1'b0;
          bit_in    = ~v[i];
          s++;
        end
      end
      @(negedge clk);
      bit_valid = 1'b1;
      bit_in    = v[i];
      last_cyc  = cyc;
    end
  endtask

  task automatic send_frame(input logic [63:0] pl, input bit flip, input bit rnd);
    logic [7:0] cv;
    cv = crc8_model(pl) ^ {7'd0, flip};
    send_bits(64'd0, 5, rnd);
    send_bits(64'hA5C3, 16, rnd);
    send_bits(pl, 64, rnd);
    send_bits({56'd0, cv}, 8, rnd);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (da_out !== 8'h00)     begin failures++; $display("FAIL rst_da_out got=%h exp=00", da_out); end
    checks++; if (da_valid !== 1'b0)    begin failures++; $display("FAIL rst_da_valid got=%b exp=0", da_valid); end
    checks++; if (sync_out !== 1'b0)    begin failures++; $display("FAIL rst_sync got=%b exp=0", sync_out); end
    checks++; if (frame_ok !== 1'b0)    begin failures++; $display("FAIL rst_frame_ok got=%b exp=0", frame_ok); end
    checks++; if (frame_err !== 1'b0)   begin failures++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
    checks++; if (err_count !== 16'h0)  begin failures++; $display("FAIL rst_err_count got=%h exp=0", err_count); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int lc;
    apply_reset(); clear_mon();
    send_frame(P1, 1'b0, 1'b0);
    lc = last_cyc;
    idle(14);
    checks++; if (ok_q.size() !== 1)  begin failures++; $display("FAIL single_ok_cnt got=%0d exp=1", ok_q.size()); end
    checks++; if (ok_q.size() > 0 && ok_q[0] !== lc + 1) begin failures++; $display("FAIL single_ok_lat got=%0d exp=%0d", ok_q[0], lc + 1); end
    checks++; if (err_q.size() !== 0) begin failures++; $display("FAIL single_err_cnt got=%0d exp=0", err_q.size()); end
    checks++; if (dv_q.size() !== 8)  begin failures++; $display("FAIL single_dv_cnt got=%0d exp=8", dv_q.size()); end
    for (int i = 0; i < 8 && i < dv_q.size(); i++) begin
      checks++; if (dv_q[i] !== lc + 2 + i) begin failures++; $display("FAIL single_dv_cyc[%0d] got=%0d exp=%0d", i, dv_q[i], lc + 2 + i); end
      checks++; if (dat_q[i] !== P1[63-8*i -: 8]) begin failures++; $display("FAIL single_da[%0d] got=%h exp=%h", i, dat_q[i], P1[63-8*i -: 8]); end
    end
    checks++; if (sync_out !== 1'b1) begin failures++; $display("FAIL single_sync got=%b exp=1", sync_out); end
    checks++; if (da_out !== 8'h08)  begin failures++; $display("FAIL single_hold got=%h exp=08", da_out); end
    checks++; if (da_valid !== 1'b0) begin failures++; $display("FAIL single_dv_idle got=%b exp=0", da_valid); end
  endtask

  task automatic test_bad_crc();
    int lc;
    apply_reset(); clear_mon();
    send_frame(P1, 1'b1, 1'b0);
    lc = last_cyc;
    idle(14);
    checks++; if (err_q.size() !== 1) begin failures++; $display("FAIL bad_err_cnt got=%0d exp=1", err_q.size()); end
    checks++; if (err_q.size() > 0 && err_q[0] !== lc + 1) begin failures++; $display("FAIL bad_err_lat got=%0d exp=%0d", err_q[0], lc + 1); end
    checks++; if (ok_q.size() !== 0)  begin failures++; $display("FAIL bad_ok_cnt got=%0d exp=0", ok_q.size()); end
    checks++; if (dv_q.size() !== 0)  begin failures++; $display("FAIL bad_dv_cnt got=%0d exp=0", dv_q.size()); end
    checks++; if (sync_out !== 1'b0)  begin failures++; $display("FAIL bad_sync got=%b exp=0", sync_out); end
  endtask

  task automatic test_lock_hold();
    bit          bad_seq [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        exp_sync[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset(); clear_mon();
    for (int f = 0; f < 7; f++) begin
      send_frame(P1, bad_seq[f], 1'b0);
      idle(12);
      checks++; if (sync_out !== exp_sync[f]) begin failures++; $display("FAIL lock_sync[%0d] got=%b exp=%b", f, sync_out, exp_sync[f]); end
    end
    checks++; if (err_q.size() !== 5) begin failures++; $display("FAIL lock_err_cnt got=%0d exp=5", err_q.size()); end
    checks++; if (ok_q.size() !== 2)  begin failures++; $display("FAIL lock_ok_cnt got=%0d exp=2", ok_q.size()); end
  endtask

  task automatic test_sync_in_payload();
    int lc;
    apply_reset(); clear_mon();
    send_frame(P2, 1'b0, 1'b1);
    lc = last_cyc;
    idle(14);
    checks++; if (ok_q.size() !== 1)  begin failures++; $display("FAIL emb_ok_cnt got=%0d exp=1", ok_q.size()); end
    checks++; if (err_q.size() !== 0) begin failures++; $display("FAIL emb_err_cnt got=%0d exp=0", err_q.size()); end
    checks++; if (dv_q.size() !== 8)  begin failures++; $display("FAIL emb_dv_cnt got=%0d exp=8", dv_q.size()); end
    for (int i = 0; i < 8 && i < dv_q.size(); i++) begin
      checks++; if (dv_q[i] !== lc + 2 + i) begin failures++; $display("FAIL emb_dv_cyc[%0d] got=%0d exp=%0d", i, dv_q[i], lc + 2 + i); end
      checks++; if (dat_q[i] !== P2[63-8*i -: 8]) begin failures++; $display("FAIL emb_da[%0d] got=%h exp=%h", i, dat_q[i], P2[63-8*i -: 8]); end
    end
    checks++; if (sync_out !== 1'b1) begin failures++; $display("FAIL emb_sync got=%b exp=1", sync_out); end
  endtask

  task automatic test_reset_midframe();
    int lc;
    apply_reset();
    send_frame(P2, 1'b0, 1'b0);
    idle(12);
    clear_mon();
    send_bits(64'd0, 5, 1'b0);
    send_bits(64'hA5C3, 16, 1'b0);
    send_bits(P1 >> 24, 40, 1'b0);
    @(negedge clk);
    reset = 1'b1; bit_valid = 1'b0;
    @(negedge clk);
    checks++; if (da_out !== 8'h00)  begin failures++; $display("FAIL mid_rst_da_out got=%h exp=00", da_out); end
    checks++; if (sync_out !== 1'b0) begin failures++; $display("FAIL mid_rst_sync got=%b exp=0", sync_out); end
    checks++; if (da_valid !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0)
      begin failures++; $display("FAIL mid_rst_pulses got=%b%b%b exp=000", da_valid, frame_ok, frame_err); end
    @(negedge clk);
    reset = 1'b0;
    idle(20);
    checks++; if (ok_q.size() + err_q.size() + dv_q.size() !== 0)
      begin failures++; $display("FAIL mid_abort_events got=%0d exp=0", ok_q.size() + err_q.size() + dv_q.size()); end
    send_frame(P1, 1'b0, 1'b0);
    lc = last_cyc;
    idle(14);
    checks++; if (ok_q.size() !== 1) begin failures++; $display("FAIL mid_ok_cnt got=%0d exp=1", ok_q.size()); end
    checks++; if (ok_q.size() > 0 && ok_q[0] !== lc + 1) begin failures++; $display("FAIL mid_ok_lat got=%0d exp=%0d", ok_q[0], lc + 1); end
    checks++; if (dv_q.size() !== 8) begin failures++; $display("FAIL mid_dv_cnt got=%0d exp=8", dv_q.size()); end
    for (int i = 0; i < 8 && i < dat_q.size(); i++) begin
      checks++; if (dat_q[i] !== P1[63-8*i -: 8]) begin failures++; $display("FAIL mid_da[%0d] got=%h exp=%h", i, dat_q[i], P1[63-8*i -: 8]); end
    end
    checks++; if (sync_out !== 1'b1) begin failures++; $display("FAIL mid_sync got=%b exp=1", sync_out); end
  endtask

  task automatic test_err_count();
    logic [15:0] exp_cnt;
`ifdef DEFRAMER_ERR_CNT_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    apply_reset(); clear_mon();
    for (int f = 0; f < 5; f++) begin
      send_frame(P1 ^ 64'(f), 1'b1, 1'b0);
      idle(4);
    end
    idle(4);
    checks++; if (err_q.size() !== 5)    begin failures++; $display("FAIL errcnt_pulses got=%0d exp=5", err_q.size()); end
    checks++; if (err_count !== exp_cnt) begin failures++; $display("FAIL errcnt_value got=%0d exp=%0d", err_count, exp_cnt); end
    checks++; if (sync_out !== 1'b0)     begin failures++; $display("FAIL errcnt_sync got=%b exp=0", sync_out); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_bad_crc();
    test_lock_hold();
    test_sync_in_payload();
    test_reset_midframe();
    test_err_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
